mux_select_rr_arbiter: RTL

Round-robin controller that drives the select line S of the NAND-built 2:1 mux and captures the mux output Z. Requesters A and B ask for the shared mux path. The arbiter grants one requester at a time and steers S accordingly. It registers the returned mux output Z with a valid flag for the downstream consumer. A hold limit prevents either requester from starving the other.

---
 rtl/mux_select_rr_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mux_select_rr_arbiter.sv
// Round-robin owner of the shared 2:1 mux path: steers S toward the granted
// requester, enforces a hold limit against starvation and registers the returned Z.
module mux_select_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic REQ_A,
    input  logic REQ_B,
    input  logic DONE,
    input  logic Z_IN,
    output logic S,
    output logic GNT_A,
    output logic GNT_B,
    output logic BUSY,
    output logic Z_Q,
    output logic Z_VALID
);

    // One-hot-style encoding so each grant is a plain flop output.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] OWN_A = 2'b01;
    localparam logic [1:0] OWN_B = 2'b10;

    localparam logic             PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             last;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_expired;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= HOLD_MAX) ? HOLD_MAX : v + CNT_W'(1);
    endfunction

    // The >= also catches a requester that shows up after the count has saturated.
    assign hold_expired = PREEMPT_EN && (hold_cnt >= HOLD_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (REQ_A && REQ_B)
                    state_nxt = last ? OWN_A : OWN_B;
                else if (REQ_A)
                    state_nxt = OWN_A;
                else if (REQ_B)
                    state_nxt = OWN_B;
            end
            OWN_A: begin
                if (DONE || !REQ_A || (REQ_B && hold_expired))
                    state_nxt = REQ_B ? OWN_B : IDLE;
            end
            OWN_B: begin
                if (DONE || !REQ_B || (REQ_A && hold_expired))
                    state_nxt = REQ_A ? OWN_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            S        <= 1'b0;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == OWN_A && state != OWN_A) begin
                S        <= 1'b0;
                last     <= 1'b0;
                hold_cnt <= '0;
            end else if (state_nxt == OWN_B && state != OWN_B) begin
                S        <= 1'b1;
                last     <= 1'b1;
                hold_cnt <= '0;
            end else if (state != IDLE) begin
                hold_cnt <= sat_inc(hold_cnt);
            end
        end
    end

    // Capture stage: samples Z while a grant is live, so it lags the grant by one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Z_Q     <= 1'b0;
            Z_VALID <= 1'b0;
        end else begin
            if (state != IDLE)
                Z_Q <= Z_IN;
            Z_VALID <= (state != IDLE);
        end
    end

    assign GNT_A = state[0];
    assign GNT_B = state[1];
    assign BUSY  = |state;

endmodule
